template_match_classifier: RTL and testbench

- Downstream consumer of the per-template difference stages (one per digit 0-9, each producing an 11x11 array of 8-bit pixel differences).
- Serially accumulates the difference pixels of each template into a distance score and tracks the minimum across all templates.
- Reports the winning digit and its score with a one-cycle valid pulse.
- Feeds the game/score logic that consumes the recognised digit.

---
 rtl/template_match_classifier.sv | 164 ++++++++++++++++
 tb/tb_template_match_classifier.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/template_match_classifier.sv
// rtl/template_match_classifier.sv - serial template distance accumulator and minimum-score digit classifier
//
// Accumulates PIXELS difference pixels per template into a distance score,
// keeps the lowest score (ties keep the lower template index) over
// NUM_TEMPLATES templates, and reports the winner with a one-cycle pulse.
//
// Optional feature macro: REJECT_THRESHOLD_EN
//   defined   : digit reports 4'hF when the best score exceeds REJECT_THRESH
//   undefined : digit is always the best template index
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset, aborts any classification
//   start        in   one-cycle request, honoured only when idle
//   diff_valid   in   diff_data valid this cycle
//   diff_data    in   DATA_W difference pixel, row-major, template by template
//   diff_ready   out  block accepts a beat (transfer = diff_valid && diff_ready)
//   busy         out  classification in progress
//   result_valid out  one-cycle pulse, digit/min_sum valid
//   digit        out  4-bit winning template index (4'hF = reject)
//   min_sum      out  SUM_W score of the winning template
module template_match_classifier #(
   parameter int PIXELS        = 121,
   parameter int NUM_TEMPLATES = 10,
   parameter int DATA_W        = 8,
   parameter int SUM_W         = 16,
   parameter int REJECT_THRESH = 4000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              diff_valid,
   input  logic [DATA_W-1:0] diff_data,
   output logic              diff_ready,
   output logic              busy,
   output logic              result_valid,
   output logic [3:0]        digit,
   output logic [SUM_W-1:0]  min_sum
);

`ifdef REJECT_THRESHOLD_EN
   localparam bit REJECT_EN = 1'b1;
`else
   localparam bit REJECT_EN = 1'b0;
`endif

   localparam int               CNT_W    = $clog2(PIXELS + 1);
   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIXELS - 1);
   localparam logic [3:0]       LAST_T   = 4'(NUM_TEMPLATES - 1);
   localparam logic [SUM_W-1:0] THRESH   = SUM_W'(REJECT_THRESH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      COMPARE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t            state;
   logic [SUM_W-1:0]  acc;
   logic [CNT_W-1:0]  pix_cnt;
   logic [3:0]        tmpl_idx;
   logic [SUM_W-1:0]  best_sum;
   logic [3:0]        best_idx;

   logic              better;
   logic [SUM_W-1:0]  nb_sum;
   logic [3:0]        nb_idx;
   logic [SUM_W-1:0]  pix_ext;

   assign pix_ext = {{(SUM_W-DATA_W){1'b0}}, diff_data};

   // Candidate best after the current template; strict less-than keeps the
   // earlier (lower) index on ties.
   always_comb begin
      better = 1'b0;
      nb_sum = best_sum;
      nb_idx = best_idx;
      if (acc < best_sum) begin
         better = 1'b1;
         nb_sum = acc;
         nb_idx = tmpl_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         diff_ready   <= 1'b0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         digit        <= 4'd0;
         min_sum      <= '0;
         acc          <= '0;
         pix_cnt      <= '0;
         tmpl_idx     <= 4'd0;
         best_sum     <= '1;
         best_idx     <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               result_valid <= 1'b0;
               if (start) begin
                  state      <= ACCUM;
                  diff_ready <= 1'b1;
                  busy       <= 1'b1;
                  acc        <= '0;
                  pix_cnt    <= '0;
                  tmpl_idx   <= 4'd0;
                  best_sum   <= '1;
                  best_idx   <= 4'd0;
               end
            end

            ACCUM: begin
               // diff_ready is high throughout ACCUM, so a valid beat transfers.
               if (diff_valid) begin
                  acc     <= acc + pix_ext;
                  pix_cnt <= pix_cnt + 1'b1;
                  if (pix_cnt == LAST_PIX) begin
                     state      <= COMPARE;
                     diff_ready <= 1'b0;
                  end
               end
            end

            COMPARE: begin
               best_sum <= nb_sum;
               best_idx <= nb_idx;
               acc      <= '0;
               pix_cnt  <= '0;
               if (tmpl_idx == LAST_T) begin
                  // Result registers load here so they are valid in DONE.
                  state        <= DONE;
                  result_valid <= 1'b1;
                  busy         <= 1'b0;
                  min_sum      <= nb_sum;
                  digit        <= (REJECT_EN && (nb_sum > THRESH)) ? 4'hF : nb_idx;
               end else begin
                  state      <= ACCUM;
                  tmpl_idx   <= tmpl_idx + 1'b1;
                  diff_ready <= 1'b1;
               end
            end

            DONE: begin
               result_valid <= 1'b0;
               state        <= IDLE;
            end

            default: begin
               state        <= IDLE;
               diff_ready   <= 1'b0;
               busy         <= 1'b0;
               result_valid <= 1'b0;
            end
         endcase
      end
   end

   logic unused_better;
   assign unused_better = better;

endmodule

// File: tb/tb_template_match_classifier.sv
// tb/tb_template_match_classifier.sv - directed self-checking bench for template_match_classifier
module tb_template_match_classifier;

   localparam int PIXELS = 121;
   localparam int NT     = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        diff_valid;
   logic [7:0]  diff_data;
   logic        diff_ready;
   logic        busy;
   logic        result_valid;
   logic [3:0]  digit;
   logic [15:0] min_sum;

   int total = 0;
   int bad   = 0;
   int pulses = 0;

   template_match_classifier dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .diff_valid   (diff_valid),
      .diff_data    (diff_data),
      .diff_ready   (diff_ready),
      .busy         (busy),
      .result_valid (result_valid),
      .digit        (digit),
      .min_sum      (min_sum)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (result_valid === 1'b1) pulses++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Spread a target sum over the template: base value everywhere, +1 on the
   // first (sum % PIXELS) pixels.
   function automatic logic [7:0] pix(input int s, input int p);
      return 8'((s / PIXELS) + ((p < (s % PIXELS)) ? 1 : 0));
   endfunction

   task automatic send_beat(input logic [7:0] d, input bit gaps);
      int w;
      if (gaps && ($urandom_range(0, 1) == 1)) begin
         diff_valid = 1'b0;
         diff_data  = 8'hAA;
         tick();
      end
      diff_valid = 1'b1;
      diff_data  = d;
      w = 0;
      while (diff_ready !== 1'b1 && w < 10) begin
         tick();
         w++;
      end
      if (diff_ready !== 1'b1) check("ready_timeout", 32'd0, 32'd1);
      tick();
      diff_valid = 1'b0;
   endtask

   task automatic classify(input int sums[NT], input bit gaps, input logic [3:0] exp_d,
                           input int exp_s, input string tag);
      int p0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_busy"}, 32'(busy), 32'd1);
      p0 = pulses;
      for (int t = 0; t < NT; t++) begin
         for (int p = 0; p < PIXELS; p++) begin
            if (t == 0 && p == 10) start = 1'b1;
            send_beat(pix(sums[t], p), gaps);
            start = 1'b0;
         end
      end
      // One cycle after the final beat: COMPARE, no result yet.
      check({tag, "_cmp_rv"}, 32'(result_valid), 32'd0);
      check({tag, "_cmp_rdy"}, 32'(diff_ready), 32'd0);
      tick();
      check({tag, "_rv"}, 32'(result_valid), 32'd1);
      check({tag, "_digit"}, 32'(digit), 32'(exp_d));
      check({tag, "_sum"}, 32'(min_sum), 32'(exp_s));
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
      tick();
      check({tag, "_rv_low"}, 32'(result_valid), 32'd0);
      check({tag, "_digit_hold"}, 32'(digit), 32'(exp_d));
      check({tag, "_pulses"}, 32'(pulses - p0), 32'd1);
   endtask

   initial begin
      int s[NT];
      int p0;
      logic [3:0] rej_digit;

      reset      = 1'b1;
      start      = 1'b0;
      diff_valid = 1'b0;
      diff_data  = 8'd0;
      tick();
      tick();
      reset = 1'b0;
      check("rst_ready", 32'(diff_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rv", 32'(result_valid), 32'd0);
      check("rst_digit", 32'(digit), 32'd0);
      check("rst_sum", 32'(min_sum), 32'd0);

      // Data offered while idle is not consumed.
      diff_valid = 1'b1;
      diff_data  = 8'hFF;
      for (int i = 0; i < 3; i++) tick();
      check("idle_ready", 32'(diff_ready), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      diff_valid = 1'b0;

      // Template 8 all zeros, others all ones.
      for (int i = 0; i < NT; i++) s[i] = 121;
      s[8] = 0;
      classify(s, 1'b0, 4'd8, 0, "t8zero");

      // All 255: full-scale sum, tie keeps index 0.
      for (int i = 0; i < NT; i++) s[i] = 30855;
      classify(s, 1'b0, 4'd0, 30855, "full");

      // Tie between 3 and 7.
      for (int i = 0; i < NT; i++) s[i] = 1000;
      s[3] = 500;
      s[7] = 500;
      classify(s, 1'b0, 4'd3, 500, "tie37");

      // Random valid gaps.
      for (int i = 0; i < NT; i++) s[i] = 200;
      s[5] = 121;
      classify(s, 1'b1, 4'd5, 121, "gaps");

      // Abort during template 4.
      start = 1'b1;
      tick();
      start = 1'b0;
      p0 = pulses;
      for (int t = 0; t < 4; t++)
         for (int p = 0; p < PIXELS; p++) send_beat(8'd3, 1'b0);
      for (int p = 0; p < 60; p++) send_beat(8'd1, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ready", 32'(diff_ready), 32'd0);
      check("abort_digit", 32'(digit), 32'd0);
      check("abort_sum", 32'(min_sum), 32'd0);
      for (int i = 0; i < 300; i++) tick();
      check("abort_pulses", 32'(pulses - p0), 32'd0);
      for (int i = 0; i < NT; i++) s[i] = 300;
      s[2] = 50;
      classify(s, 1'b0, 4'd2, 50, "after_abort");

      // All sums 5000: rejected only when the threshold feature is built in.
`ifdef REJECT_THRESHOLD_EN
      rej_digit = 4'hF;
`else
      rej_digit = 4'd0;
`endif
      for (int i = 0; i < NT; i++) s[i] = 5000;
      classify(s, 1'b0, rej_digit, 5000, "reject");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
